// File: rtl/clock_pkg.sv
// Shared field widths, limits and alarm FSM states
// for the digital clock family.
package clock_pkg;
   localparam int SEC_W  = 6;
   localparam int MIN_W  = 6;
   localparam int HOUR_W = 5;

   localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
   localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
   localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } alarm_state_t;
endpackage

// File: rtl/tick_prescaler.sv
// Divides the board clock down to a one-cycle tick
// every TICK_DIV cycles while run is high.
module tick_prescaler #(
   parameter int TICK_DIV = 50_000_000,
   parameter int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic tick
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = run & (cnt == LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (run)
         cnt <= tick ? '0 : cnt + CNT_W'(1);
   end
endmodule

// File: rtl/digital_clock_alarm.sv
// Time-of-day counter with load, 12/24h display and
// an alarm that supports snooze and self-timeout.
module digital_clock_alarm
   import clock_pkg::*;
#(
   parameter int TICK_DIV   = 50_000_000,
   parameter int CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1,
   parameter int RING_SECS  = 60,
   parameter int SNOOZE_MIN = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic              mode_12h,
   input  logic              set_load,
   input  logic [HOUR_W-1:0] set_hour,
   input  logic [MIN_W-1:0]  set_min,
   input  logic [SEC_W-1:0]  set_sec,
   output logic              set_err,
   input  logic              alarm_en,
   input  logic [HOUR_W-1:0] alarm_hour,
   input  logic [MIN_W-1:0]  alarm_min,
   input  logic              alarm_ack,
   input  logic              alarm_snooze,
   output logic [SEC_W-1:0]  sec,
   output logic [MIN_W-1:0]  min,
   output logic [HOUR_W-1:0] hour,
   output logic [HOUR_W-1:0] disp_hour,
   output logic              pm,
   output logic              sec_tick,
   output logic              alarm_ring
);
   localparam int RC_W = $clog2(RING_SECS + 1);

   logic              tick, load_ok, adv;
   logic [SEC_W-1:0]  nsec;
   logic [MIN_W-1:0]  nmin, snz_min, tgt_min;
   logic [HOUR_W-1:0] nhour, snz_hour, tgt_hour;
   logic [MIN_W:0]    msum;
   logic [RC_W-1:0]   ring_cnt;
   logic              hit_alarm, hit_snz;
   alarm_state_t      state;

   assign load_ok = set_load && (set_sec <= SEC_MAX)
                    && (set_min <= MIN_MAX)
                    && (set_hour <= HOUR_MAX);
   assign adv = tick && !set_load;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (CNT_W)
   ) u_presc (
      .clock (clock),
      .reset (reset),
      .run   (run),
      .clear (load_ok),
      .tick  (tick)
   );

   always_comb begin
      nsec  = sec + SEC_W'(1);
      nmin  = min;
      nhour = hour;
      if (sec == SEC_MAX) begin
         nsec = '0;
         nmin = min + MIN_W'(1);
         if (min == MIN_MAX) begin
            nmin  = '0;
            nhour = (hour == HOUR_MAX) ? '0 : hour + HOUR_W'(1);
         end
      end
   end

   // Snooze target, wrapping minutes into the next hour.
   always_comb begin
      msum     = {1'b0, min} + (MIN_W+1)'(SNOOZE_MIN);
      tgt_min  = msum[MIN_W-1:0];
      tgt_hour = hour;
      if (msum > {1'b0, MIN_MAX}) begin
         tgt_min  = MIN_W'(msum - (MIN_W+1)'(60));
         tgt_hour = (hour == HOUR_MAX) ? '0 : hour + HOUR_W'(1);
      end
   end

   assign hit_alarm = adv && (nsec == '0) && (nhour == alarm_hour)
                      && (nmin == alarm_min);
   assign hit_snz   = adv && (nsec == '0) && (nhour == snz_hour)
                      && (nmin == snz_min);

   always_comb begin
      disp_hour = hour;
      if (mode_12h) begin
         if (hour == '0)
            disp_hour = HOUR_W'(12);
         else if (hour > HOUR_W'(12))
            disp_hour = hour - HOUR_W'(12);
      end
   end

   assign pm = (hour >= HOUR_W'(12));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sec      <= '0;
         min      <= '0;
         hour     <= '0;
         set_err  <= 1'b0;
         sec_tick <= 1'b0;
      end else begin
         set_err  <= set_load && !load_ok;
         sec_tick <= adv;
         if (load_ok) begin
            sec  <= set_sec;
            min  <= set_min;
            hour <= set_hour;
         end else if (adv) begin
            sec  <= nsec;
            min  <= nmin;
            hour <= nhour;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         alarm_ring <= 1'b0;
         ring_cnt   <= '0;
         snz_hour   <= '0;
         snz_min    <= '0;
      end else if (load_ok) begin
         state      <= IDLE;
         alarm_ring <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (alarm_en && hit_alarm) begin
                  state      <= RING;
                  alarm_ring <= 1'b1;
                  ring_cnt   <= '0;
               end
            end
            RING: begin
               if (!alarm_en || alarm_ack) begin
                  state      <= IDLE;
                  alarm_ring <= 1'b0;
               end else if (alarm_snooze) begin
                  state      <= SNOOZE;
                  alarm_ring <= 1'b0;
                  snz_hour   <= tgt_hour;
                  snz_min    <= tgt_min;
               end else if (adv) begin
                  if (ring_cnt == RC_W'(RING_SECS - 1)) begin
                     state      <= IDLE;
                     alarm_ring <= 1'b0;
                  end else begin
                     ring_cnt <= ring_cnt + RC_W'(1);
                  end
               end
            end
            SNOOZE: begin
               if (!alarm_en) begin
                  state <= IDLE;
               end else if (hit_snz) begin
                  state      <= RING;
                  alarm_ring <= 1'b1;
                  ring_cnt   <= '0;
               end
            end
            default: begin
               state      <= IDLE;
               alarm_ring <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_digital_clock_alarm.sv
// Directed bench for digital_clock_alarm with a short
// prescaler, short ring timeout and 5-minute snooze.
module tb_digital_clock_alarm;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b0, mode_12h = 1'b0, set_load = 1'b0;
   logic [4:0] set_hour = '0;
   logic [5:0] set_min = '0, set_sec = '0;
   logic       set_err;
   logic       alarm_en = 1'b0, alarm_ack = 1'b0, alarm_snooze = 1'b0;
   logic [4:0] alarm_hour = '0;
   logic [5:0] alarm_min = '0;
   logic [5:0] sec, min;
   logic [4:0] hour, disp_hour;
   logic       pm, sec_tick, alarm_ring;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int h;
      int m12;
      int disp;
      int pm;
   } vec_t;

   vec_t tbl[10];

   digital_clock_alarm #(
      .TICK_DIV   (4),
      .RING_SECS  (3),
      .SNOOZE_MIN (5)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .run          (run),
      .mode_12h     (mode_12h),
      .set_load     (set_load),
      .set_hour     (set_hour),
      .set_min      (set_min),
      .set_sec      (set_sec),
      .set_err      (set_err),
      .alarm_en     (alarm_en),
      .alarm_hour   (alarm_hour),
      .alarm_min    (alarm_min),
      .alarm_ack    (alarm_ack),
      .alarm_snooze (alarm_snooze),
      .sec          (sec),
      .min          (min),
      .hour         (hour),
      .disp_hour    (disp_hour),
      .pm           (pm),
      .sec_tick     (sec_tick),
      .alarm_ring   (alarm_ring)
   );

   always #5 clock = ~clock;

   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_time(input string nm, input int h, input int m, input int s);
      chk({nm, "_hour"}, int'(hour), h);
      chk({nm, "_min"}, int'(min), m);
      chk({nm, "_sec"}, int'(sec), s);
   endtask

   task automatic load(input int h, input int m, input int s);
      set_hour = 5'(h);
      set_min  = 6'(m);
      set_sec  = 6'(s);
      set_load = 1'b1;
      cyc();
      set_load = 1'b0;
   endtask

   task automatic wait_ring(input string nm, input int budget);
      int found;
      found = 0;
      for (int i = 0; i < budget && found == 0; i++) begin
         cyc();
         if (alarm_ring) found = 1;
      end
      chk({nm, "_rose"}, found, 1);
   endtask

   initial begin
      int ticks, first;

      tbl[0] = '{0, 0, 0, 0};
      tbl[1] = '{0, 1, 12, 0};
      tbl[2] = '{1, 1, 1, 0};
      tbl[3] = '{11, 1, 11, 0};
      tbl[4] = '{12, 1, 12, 1};
      tbl[5] = '{12, 0, 12, 1};
      tbl[6] = '{13, 1, 1, 1};
      tbl[7] = '{13, 0, 13, 1};
      tbl[8] = '{23, 1, 11, 1};
      tbl[9] = '{23, 0, 23, 1};

      // Reset state and basic counting
      cyc(2);
      chk_time("rst", 0, 0, 0);
      chk("rst_tick", int'(sec_tick), 0);
      chk("rst_ring", int'(alarm_ring), 0);
      chk("rst_err", int'(set_err), 0);
      reset = 1'b0;
      run   = 1'b1;
      ticks = 0;
      first = -1;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         if (sec_tick) begin
            ticks++;
            if (first < 0) first = i;
         end
      end
      chk("run8_ticks", ticks, 2);
      chk("run8_first", first, 4);
      chk("run8_sec", int'(sec), 2);
      run   = 1'b0;
      ticks = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (sec_tick) ticks++;
      end
      chk("pause_ticks", ticks, 0);
      chk("pause_sec", int'(sec), 2);

      // Rollover through midnight
      run = 1'b1;
      load(23, 59, 58);
      chk("ld_err", int'(set_err), 0);
      chk_time("ld", 23, 59, 58);
      cyc(4);
      chk_time("roll1", 23, 59, 59);
      cyc(4);
      chk_time("roll2", 0, 0, 0);
      mode_12h = 1'b1;
      #1;
      chk("mid_disp", int'(disp_hour), 12);
      chk("mid_pm", int'(pm), 0);
      mode_12h = 1'b0;
      cyc(4);
      chk_time("roll3", 0, 0, 1);

      // Display table
      run = 1'b0;
      foreach (tbl[k]) begin
         load(tbl[k].h, 0, 0);
         mode_12h = tbl[k].m12 != 0;
         #1;
         chk($sformatf("disp%0d", k), int'(disp_hour), tbl[k].disp);
         chk($sformatf("pm%0d", k), int'(pm), tbl[k].pm);
      end
      mode_12h = 1'b0;

      // Rejected loads
      load(10, 20, 30);
      load(1, 60, 0);
      chk("bad_min_err", int'(set_err), 1);
      chk_time("bad_min", 10, 20, 30);
      cyc();
      chk("err_pulse", int'(set_err), 0);
      load(24, 0, 0);
      chk("bad_hour_err", int'(set_err), 1);
      chk_time("bad_hour", 10, 20, 30);

      // Load in the same cycle as a tick
      run = 1'b1;
      load(10, 20, 30);
      cyc(3);
      load(5, 6, 7);
      chk_time("ldtick", 5, 6, 7);
      chk("ldtick_stick", int'(sec_tick), 0);
      cyc(3);
      chk("restart_hold", int'(sec), 7);
      cyc();
      chk("restart_sec", int'(sec), 8);
      chk("restart_stick", int'(sec_tick), 1);

      // Alarm with timeout
      alarm_en   = 1'b1;
      alarm_hour = 5'd7;
      alarm_min  = 6'd30;
      load(7, 29, 59);
      chk("ld_noring", int'(alarm_ring), 0);
      cyc(4);
      chk_time("al", 7, 30, 0);
      chk("al_ring", int'(alarm_ring), 1);
      cyc(11);
      chk("al_still", int'(alarm_ring), 1);
      cyc();
      chk("al_timeout", int'(alarm_ring), 0);
      chk_time("al_to", 7, 30, 3);

      // Snooze then ack
      load(7, 29, 59);
      cyc(4);
      chk("snz_ring0", int'(alarm_ring), 1);
      alarm_snooze = 1'b1;
      cyc();
      alarm_snooze = 1'b0;
      chk("snz_drop", int'(alarm_ring), 0);
      wait_ring("snz", 1400);
      chk_time("snz_at", 7, 35, 0);
      alarm_ack = 1'b1;
      cyc();
      alarm_ack = 1'b0;
      chk("ack_drop", int'(alarm_ring), 0);
      cyc(16);
      chk("ack_stays", int'(alarm_ring), 0);

      // Snooze across midnight, then reset mid-ring
      alarm_hour = 5'd23;
      alarm_min  = 6'd58;
      load(23, 57, 59);
      cyc(4);
      chk("wrap_ring0", int'(alarm_ring), 1);
      alarm_snooze = 1'b1;
      cyc();
      alarm_snooze = 1'b0;
      wait_ring("wrap", 1400);
      chk_time("wrap_at", 0, 3, 0);
      reset = 1'b1;
      #1;
      chk_time("arst", 0, 0, 0);
      chk("arst_ring", int'(alarm_ring), 0);
      chk("arst_tick", int'(sec_tick), 0);
      chk("arst_disp", int'(disp_hour), 0);
      cyc();
      reset = 1'b0;
      alarm_hour = 5'd0;
      alarm_min  = 6'd0;
      cyc(16);
      chk("post_rst_sec", int'(sec), 4);
      chk("post_rst_ring", int'(alarm_ring), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/digital_clock_alarm.md
Name: digital_clock_alarm

Overview:
- Parametrised successor to the base digital_clock (sec/min/hour counters).
- Adds a programmable prescaler, run/pause, time load with range check, 12/24-hour display, and an alarm with snooze and auto-timeout.
- Sits between the board clock and the display/annunciator logic, producing binary time fields plus a once-per-second strobe.

Parameters:
- TICK_DIV, 50_000_000: clock cycles per second tick; legal range is 1 or more.
- CNT_W, $clog2(TICK_DIV) or 1 when TICK_DIV is 1: width of the prescaler counter.
- RING_SECS, 60: seconds the alarm rings before it self-clears.
- SNOOZE_MIN, 5: minutes added on snooze; legal range is 1 to 59.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  1 = prescaler counts; 0 = time frozen.
- mode_12h  in  1  display format select: 1 = 12-hour, 0 = 24-hour.
- set_load  in  1  one-cycle request to load time.
- set_hour  in  5  value loaded into hour.
- set_min  in  6  value loaded into min.
- set_sec  in  6  value loaded into sec.
- set_err  out  1  one-cycle pulse when a load is rejected.
- alarm_en  in  1  arms the alarm.
- alarm_hour  in  5  alarm hour, 0 to 23.
- alarm_min  in  6  alarm minute, 0 to 59.
- alarm_ack  in  1  stops ringing.
- alarm_snooze  in  1  stops ringing and re-arms SNOOZE_MIN minutes later.
- sec  out  6  seconds, 0 to 59.
- min  out  6  minutes, 0 to 59.
- hour  out  5  hour in 24-hour form, 0 to 23.
- disp_hour  out  5  hour formatted per mode_12h.
- pm  out  1  1 when hour is 12 or more.
- sec_tick  out  1  one-cycle pulse on each counter advance.
- alarm_ring  out  1  high while the alarm is ringing.

Behaviour:
- Reset (async, active-high) clears:
  - prescaler, sec, min, hour, set_err, sec_tick, alarm_ring, ring counter and snooze target all to 0;
  - FSM to IDLE.
- Prescaler:
  - When run=1, counts 0 to TICK_DIV-1 and wraps.
  - An internal tick fires on the cycle the count equals TICK_DIV-1.
  - When run=0, the count holds and no tick fires.
  - With TICK_DIV=1, a tick fires every cycle while run=1.
- Time update on tick, registered, visible the cycle after the tick:
  - sec increments; 59 wraps to 0 and carries to min.
  - min 59 wraps to 0 and carries to hour.
  - hour 23 wraps to 0.
  - sec_tick is registered high on the same edge the counters advance.
- Load:
  - set_load has priority over tick in the same cycle.
  - If set_sec≤59, set_min≤59 and set_hour≤23: fields load on the next edge, the prescaler clears to 0, and no sec_tick is issued for that cycle.
  - Otherwise: nothing changes and set_err pulses for one cycle.
  - A load in any FSM state forces the FSM to IDLE and drops alarm_ring.
- Display (combinational from hour and mode_12h):
  - pm = (hour≥12), independent of mode.
  - mode_12h=0: disp_hour = hour.
  - mode_12h=1: hour 0 maps to 12, 1 to 12 map to themselves, 13 to 23 map to hour-12.
- Alarm FSM (states IDLE, RING, SNOOZE):
  - IDLE to RING: alarm_en=1 and a tick advances the time to alarm_hour:alarm_min:00. alarm_ring rises on that same edge; the ring counter clears.
  - A load that lands on the alarm time does not trigger the alarm.
  - In RING, priority order is alarm_en=0, then alarm_ack, then alarm_snooze, then timeout:
    - alarm_en=0 goes to IDLE.
    - alarm_ack goes to IDLE.
    - alarm_snooze goes to SNOOZE and latches target = current hour:min + SNOOZE_MIN, wrapping mod 60 minutes and mod 24 hours.
    - Timeout: the ring counter increments per tick; on the RING_SECS-th tick the FSM goes to IDLE.
  - alarm_ring is 1 exactly while in RING.
  - SNOOZE to RING: a tick advances the time to target:00.
  - SNOOZE to IDLE: alarm_en=0.
  - While in SNOOZE, the original alarm time does not re-trigger.
  - run=0 freezes the timeout, because no ticks occur.

Decomposition:
- Shared package clock_pkg holds:
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23;
  - field widths 6, 6 and 5;
  - the alarm FSM state enum.
- One natural sub-module, tick_prescaler, carries parameter TICK_DIV and ports clock, reset, run, clear and tick.
- Time counters, load check, display mapping and alarm FSM stay in the top module.

Test Plan (all scenarios use TICK_DIV=4, RING_SECS=3, SNOOZE_MIN=5):
- Reset, run=1 for 8 cycles: sec reaches 2; sec_tick pulses every 4th cycle; set run=0 and hold 10 cycles, sec stays 2.
- Load 23:59:58, run for 3 ticks: reads 23:59:59, then 00:00:00, then 00:00:01. With mode_12h=1 at 00:00:00, disp_hour=12 and pm=0. At hour 13, disp_hour=1 and pm=1.
- Load with set_min=60: set_err pulses one cycle and time is unchanged. Assert set_load in the same cycle as a tick: the loaded value wins and the prescaler restarts.
- Alarm 07:30, load 07:29:59, one tick: alarm_ring rises at 07:30:00 and falls after 3 further ticks with no ack.
- While ringing at 07:30, pulse alarm_snooze: ring drops. At 07:35:00, ring rises again. alarm_ack then clears it.
- Snooze target wrap: alarm 23:58 with snooze gives target 00:03. Assert reset mid-RING: all outputs return to 0 and the FSM to IDLE.
